// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, flush and instruction field decode.
// Optional stall counter is built when IF_ID_STALL_CNT_EN is defined.
module if_id_stage #(
    parameter logic [31:0] NOP_INST = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_IDIn,
    input  logic [31:0] PCPlus4In,
    input  logic        PCSrc,
    input  logic        ID_EXMemRead,
    input  logic [4:0]  ID_EXRt,
    output logic        Hazard,
    output logic [31:0] InstOut,
    output logic [31:0] PCPlus4Out,
    output logic        ValidOut,
    output logic [5:0]  Opcode,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [4:0]  Shamt,
    output logic [5:0]  Funct,
    output logic [15:0] Imm16,
    output logic [15:0] StallCount
);

    assign Opcode = InstOut[31:26];
    assign Rs     = InstOut[25:21];
    assign Rt     = InstOut[20:16];
    assign Rd     = InstOut[15:11];
    assign Shamt  = InstOut[10:6];
    assign Funct  = InstOut[5:0];
    assign Imm16  = InstOut[15:0];

    // A bubble never stalls fetch, and $zero is never a real dependency.
    assign Hazard = ValidOut & ID_EXMemRead & (ID_EXRt != 5'd0) &
                    ((ID_EXRt == Rs) | (ID_EXRt == Rt));

    // Priority: reset, then flush, then stall (hold), then normal load.
    always_ff @(posedge clk) begin
        if (rst) begin
            InstOut    <= NOP_INST;
            PCPlus4Out <= 32'h0;
            ValidOut   <= 1'b0;
        end else if (PCSrc) begin
            InstOut    <= NOP_INST;
            PCPlus4Out <= 32'h0;
            ValidOut   <= 1'b0;
        end else if (!Hazard) begin
            InstOut    <= IF_IDIn;
            PCPlus4Out <= PCPlus4In;
            ValidOut   <= 1'b1;
        end
    end

`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] stall_cnt;

    // Counts only stalls that actually hold the register; saturates rather than wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
        end else if (Hazard && !PCSrc && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign StallCount = stall_cnt;
`else
    assign StallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: expected register state is queued as each cycle's
// stimulus is driven and compared one clock later; Hazard is compared before the edge.
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] IF_IDIn = '0;
    logic [31:0] PCPlus4In = '0;
    logic        PCSrc = 1'b0;
    logic        ID_EXMemRead = 1'b0;
    logic [4:0]  ID_EXRt = '0;
    logic        Hazard;
    logic [31:0] InstOut, PCPlus4Out;
    logic        ValidOut;
    logic [5:0]  Opcode, Funct;
    logic [4:0]  Rs, Rt, Rd, Shamt;
    logic [15:0] Imm16, StallCount;

    if_id_stage #(.NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .IF_IDIn(IF_IDIn), .PCPlus4In(PCPlus4In),
        .PCSrc(PCSrc), .ID_EXMemRead(ID_EXMemRead), .ID_EXRt(ID_EXRt),
        .Hazard(Hazard), .InstOut(InstOut), .PCPlus4Out(PCPlus4Out),
        .ValidOut(ValidOut), .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd),
        .Shamt(Shamt), .Funct(Funct), .Imm16(Imm16), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    logic hz_q[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] m_inst  = NOP;
    logic [31:0] m_pc    = '0;
    logic        m_valid = 1'b0;
    logic [15:0] m_cnt   = '0;

    function automatic logic [15:0] exp_cnt(input logic [15:0] c);
`ifdef IF_ID_STALL_CNT_EN
        return c;
`else
        return 16'h0000;
`endif
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue what the DUT must show.
    task automatic drive(input logic r, input logic [31:0] inst, input logic [31:0] pc,
                         input logic f, input logic m, input logic [4:0] rt);
        logic hz;
        exp_t e;
        @(negedge clk);
        rst = r; IF_IDIn = inst; PCPlus4In = pc; PCSrc = f; ID_EXMemRead = m; ID_EXRt = rt;
        hz = m_valid && m && (rt != 5'd0) && ((rt == m_inst[25:21]) || (rt == m_inst[20:16]));
        hz_q.push_back(hz);
        if (r) begin
            m_inst = NOP; m_pc = '0; m_valid = 1'b0; m_cnt = '0;
        end else if (f) begin
            m_inst = NOP; m_pc = '0; m_valid = 1'b0;
        end else if (hz) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
            m_inst = inst; m_pc = pc; m_valid = 1'b1;
        end
        e.inst = m_inst; e.pc = m_pc; e.valid = m_valid; e.cnt = exp_cnt(m_cnt);
        sb_q.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic h;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hDEAD0000 + i, 32'h100 + i, i[0], 1'b0, 5'd3);
            h = hz_q.pop_front();
            checks++;
            if (Hazard !== h) begin
                errors++; $display("FAIL reset_hazard[%0d]: got %b expected %b", i, Hazard, h);
            end
            @(posedge clk); #1;
            e = sb_q.pop_front();
            checks++;
            if ({InstOut, PCPlus4Out, ValidOut, StallCount} !== e) begin
                errors++;
                $display("FAIL reset_state[%0d]: got inst=%h pc=%h v=%b cnt=%h expected inst=%h pc=%h v=%b cnt=%h",
                         i, InstOut, PCPlus4Out, ValidOut, StallCount, e.inst, e.pc, e.valid, e.cnt);
            end
        end
    endtask

    task automatic test_load_decode();
        exp_t e;
        drive(1'b0, 32'h8C220004, 32'h00000004, 1'b0, 1'b0, 5'd0);
        void'(hz_q.pop_front());
        @(posedge clk); #1;
        e = sb_q.pop_front();
        checks++;
        if ({InstOut, PCPlus4Out, ValidOut, StallCount} !== e) begin
            errors++;
            $display("FAIL load_state: got inst=%h pc=%h v=%b cnt=%h expected inst=%h pc=%h v=%b cnt=%h",
                     InstOut, PCPlus4Out, ValidOut, StallCount, e.inst, e.pc, e.valid, e.cnt);
        end
        checks++;
        if ({Opcode, Rs, Rt, Imm16} !== {6'h23, 5'd1, 5'd2, 16'h0004}) begin
            errors++;
            $display("FAIL load_decode: got op=%h rs=%0d rt=%0d imm=%h expected op=23 rs=1 rt=2 imm=0004",
                     Opcode, Rs, Rt, Imm16);
        end
        drive(1'b0, 32'h0262202A, 32'h00000008, 1'b0, 1'b0, 5'd0);
        void'(hz_q.pop_front());
        @(posedge clk); #1;
        e = sb_q.pop_front();
        checks++;
        if ({Rs, Rt, Rd, Shamt, Funct} !== {5'd19, 5'd2, 5'd4, 5'd0, 6'h2A}) begin
            errors++;
            $display("FAIL rtype_decode: got rs=%0d rt=%0d rd=%0d sh=%0d fn=%h expected rs=19 rt=2 rd=4 sh=0 fn=2a",
                     Rs, Rt, Rd, Shamt, Funct);
        end
    endtask

    // Each row: inst, pc, flush, memread, rt. Covers stall on Rt, stall on Rs, $zero, flush-over-stall.
    task automatic run_rows(input string name, input logic [31:0] insts[], input logic [31:0] pcs[],
                            input logic fl[], input logic mr[], input logic [4:0] rts[]);
        exp_t e;
        logic h;
        for (int i = 0; i < insts.size(); i++) begin
            drive(1'b0, insts[i], pcs[i], fl[i], mr[i], rts[i]);
            h = hz_q.pop_front();
            checks++;
            if (Hazard !== h) begin
                errors++; $display("FAIL %s_hazard[%0d]: got %b expected %b", name, i, Hazard, h);
            end
            @(posedge clk); #1;
            e = sb_q.pop_front();
            checks++;
            if ({InstOut, PCPlus4Out, ValidOut, StallCount} !== e) begin
                errors++;
                $display("FAIL %s_state[%0d]: got inst=%h pc=%h v=%b cnt=%h expected inst=%h pc=%h v=%b cnt=%h",
                         name, i, InstOut, PCPlus4Out, ValidOut, StallCount, e.inst, e.pc, e.valid, e.cnt);
            end
        end
    endtask

    task automatic test_stall();
        run_rows("stall",
            '{32'h00221820, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
            '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{5'd0, 5'd2, 5'd2, 5'd0, 5'd0});
        run_rows("stall_rs",
            '{32'h00221820, 32'h55555555, 32'h66666666},
            '{32'h30, 32'h34, 32'h38},
            '{1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1},
            '{5'd0, 5'd1, 5'd7});
    endtask

    task automatic test_zero_rt();
        run_rows("zero_rt",
            '{32'h00021820, 32'h77777777, 32'h00221820, 32'h88888888},
            '{32'h40, 32'h44, 32'h48, 32'h4C},
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b1},
            '{5'd0, 5'd0, 5'd0, 5'd0});
    endtask

    task automatic test_flush();
        run_rows("flush",
            '{32'h00221820, 32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB},
            '{32'h50, 32'h54, 32'h58, 32'h5C},
            '{1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b0},
            '{5'd0, 5'd2, 5'd0, 5'd0});
    endtask

    task automatic test_reset_mid_stall();
        exp_t e;
        logic h;
        drive(1'b0, 32'h00221820, 32'h60, 1'b0, 1'b0, 5'd0);
        void'(hz_q.pop_front()); @(posedge clk); #1; void'(sb_q.pop_front());
        drive(1'b0, 32'hCCCCCCCC, 32'h64, 1'b0, 1'b1, 5'd2);
        void'(hz_q.pop_front()); @(posedge clk); #1; void'(sb_q.pop_front());
        drive(1'b1, 32'hDDDDDDDD, 32'h68, 1'b1, 1'b1, 5'd2);
        h = hz_q.pop_front();
        checks++;
        if (Hazard !== h) begin
            errors++; $display("FAIL rst_stall_hazard: got %b expected %b", Hazard, h);
        end
        @(posedge clk); #1;
        e = sb_q.pop_front();
        checks++;
        if ({InstOut, PCPlus4Out, ValidOut, StallCount, Hazard} !== {e, 1'b0}) begin
            errors++;
            $display("FAIL rst_stall_state: got inst=%h pc=%h v=%b cnt=%h hz=%b expected inst=%h pc=%h v=%b cnt=%h hz=0",
                     InstOut, PCPlus4Out, ValidOut, StallCount, Hazard, e.inst, e.pc, e.valid, e.cnt);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic h;
        logic [4:0] rt;
        for (int i = 0; i < 40; i++) begin
            rt = 5'($urandom_range(0, 4));
            drive(1'b0, {6'h00, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), 16'($urandom)},
                  32'h1000 + 32'(i * 4), ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, rt);
            h = hz_q.pop_front();
            checks++;
            if (Hazard !== h) begin
                errors++; $display("FAIL b2b_hazard[%0d]: got %b expected %b", i, Hazard, h);
            end
            @(posedge clk); #1;
            e = sb_q.pop_front();
            checks++;
            if ({InstOut, PCPlus4Out, ValidOut, StallCount} !== e) begin
                errors++;
                $display("FAIL b2b_state[%0d]: got inst=%h pc=%h v=%b cnt=%h expected inst=%h pc=%h v=%b cnt=%h",
                         i, InstOut, PCPlus4Out, ValidOut, StallCount, e.inst, e.pc, e.valid, e.cnt);
            end
        end
    endtask

    task automatic test_saturation();
        drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        void'(hz_q.pop_front()); @(posedge clk); #1; void'(sb_q.pop_front());
        drive(1'b0, 32'h00221820, 32'h200, 1'b0, 1'b0, 5'd0);
        void'(hz_q.pop_front()); @(posedge clk); #1; void'(sb_q.pop_front());
        @(negedge clk);
        IF_IDIn = 32'hEEEEEEEE; PCPlus4In = 32'h204; ID_EXMemRead = 1'b1; ID_EXRt = 5'd2;
        repeat (65540) @(posedge clk);
        #1;
        m_cnt = 16'hFFFF;
        checks++;
        if ({InstOut, PCPlus4Out, ValidOut, StallCount, Hazard} !==
            {32'h00221820, 32'h200, 1'b1, exp_cnt(m_cnt), 1'b1}) begin
            errors++;
            $display("FAIL saturation: got inst=%h pc=%h v=%b cnt=%h hz=%b expected inst=00221820 pc=00000200 v=1 cnt=%h hz=1",
                     InstOut, PCPlus4Out, ValidOut, StallCount, Hazard, exp_cnt(m_cnt));
        end
        test_reset_mid_stall();
    endtask

    initial begin
        test_reset();
        test_load_decode();
        test_stall();
        test_zero_rt();
        test_flush();
        test_reset_mid_stall();
        test_back_to_back();
        test_saturation();
        checks++;
        if (sb_q.size() != 0 || hz_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left expected 0/0", sb_q.size(), hz_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h00000000, the instruction word inserted on flush/reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port IF_IDIn  input  32  fetched instruction from the fetch stage.
REQ-005 SHALL have port PCPlus4In  input  32  fetch-stage PC+4 for the same instruction.
REQ-006 SHALL have port PCSrc  input  1  branch taken, resolved downstream; flushes this stage.
REQ-007 SHALL have port ID_EXMemRead  input  1  instruction currently in ID/EX is a load.
REQ-008 SHALL have port ID_EXRt  input  5  destination register of that load.
REQ-009 SHALL have port Hazard  output  1  load-use stall request to the fetch stage (1 = hold PC).
REQ-010 SHALL have ports InstOut output 32 and PCPlus4Out output 32, holding the registered instruction and PC+4.
REQ-011 SHALL have port ValidOut  output  1  registered instruction is real, not a bubble.
REQ-012 SHALL have decoded outputs Opcode[5:0]=InstOut[31:26], Rs[4:0]=[25:21], Rt[4:0]=[20:16], Rd[4:0]=[15:11], Shamt[4:0]=[10:6], Funct[5:0]=[5:0], Imm16[15:0]=[15:0], all combinational from InstOut.
REQ-013 SHALL have port StallCount  output  16  stall statistics (present only per REQ-026).

Function
REQ-014 SHALL compute Hazard combinationally = ValidOut & ID_EXMemRead & (ID_EXRt != 0) & ((ID_EXRt == Rs) | (ID_EXRt == Rt)).
REQ-015 SHALL update registers each posedge with priority: rst > PCSrc flush > Hazard stall > normal load.
REQ-016 Normal load: InstOut<=IF_IDIn, PCPlus4Out<=PCPlus4In, ValidOut<=1; latency exactly one cycle.
REQ-017 Flush (PCSrc=1): InstOut<=NOP_INST, PCPlus4Out<=0, ValidOut<=0, regardless of Hazard.
REQ-018 Stall (Hazard=1, PCSrc=0): InstOut, PCPlus4Out, ValidOut hold their values.
REQ-019 A held instruction SHALL reload on the first cycle Hazard falls to 0; one load produces at most one stall cycle since ID/EX carries a bubble next cycle.
REQ-020 Hazard SHALL be 0 whenever ValidOut=0, so a bubble never stalls fetch.
REQ-021 ID_EXRt=0 SHALL never raise Hazard (register $zero).
REQ-022 SHALL contain no internal state other than InstOut, PCPlus4Out, ValidOut and the optional counter.

Reset
REQ-023 On rst=1 at posedge: InstOut=NOP_INST, PCPlus4Out=0, ValidOut=0, StallCount=0; Hazard therefore 0 the following cycle.
REQ-024 rst SHALL override a concurrent flush or stall; reset mid-stall discards the held instruction.
REQ-025 With rst held, outputs SHALL remain at reset values every cycle.

Configuration
REQ-026 Macro IF_ID_STALL_CNT_EN: defined -> StallCount increments by 1 on every posedge where Hazard=1 and PCSrc=0 and rst=0, saturating at 16'hFFFF; undefined -> counter logic absent and StallCount tied to 16'h0000.

Verification
REQ-027 rst=1 one cycle, then IF_IDIn=32'h8C220004, PCPlus4In=32'h4 -> next cycle InstOut=32'h8C220004, ValidOut=1, Rs=1, Rt=2, Imm16=16'h0004.
REQ-028 InstOut=32'h00221820 (add $3,$1,$2) loaded, ID_EXMemRead=1, ID_EXRt=2 -> Hazard=1 same cycle; next posedge InstOut unchanged, StallCount=1 (macro on); ID_EXMemRead=0 -> load of new IF_IDIn.
REQ-029 Same as REQ-028 with ID_EXRt=0 -> Hazard=0, no stall.
REQ-030 Hazard=1 and PCSrc=1 same cycle -> next posedge InstOut=32'h00000000, ValidOut=0, Hazard=0, StallCount unchanged.
REQ-031 rst asserted during stall -> InstOut=NOP_INST, ValidOut=0, StallCount=0; force 65540 stall cycles with macro on -> StallCount=16'hFFFF; macro off -> StallCount=0 throughout.
